timer_regs: RTL and testbench



---
 rtl/timer_regs.sv | 141 ++++++++++++++
 tb/tb_timer_regs.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/timer_regs.sv
// timer_regs: DMG timer block (DIV/TIMA/TMA/TAC) responding at BASE_ADDR..BASE_ADDR+3, with TIMA overflow/reload sequencing.
// Optional TIMER_DIV_GLITCH_EN: DIV/TAC writes that drop the selected tick bit produce a TIMA increment.
module timer_regs #(
  parameter logic [15:0] BASE_ADDR = 16'hFF04
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  t_cycle,
  input  logic [15:0] mem_addr,
  input  logic        mem_enable,
  input  logic        mem_write,
  input  logic [7:0]  mem_wdata,
  output logic [7:0]  mem_rdata,
  output logic        mem_hit,
  output logic        irq_timer
);
  typedef enum logic [1:0] {IDLE, PENDING, RELOAD} state_t;

  logic [15:0] sys_cnt;
  logic [7:0]  tima;
  logic [7:0]  tma;
  logic [2:0]  tac;
  state_t      state;
  logic [1:0]  k;
  logic        edge_prev;

  logic        wr_en;
  logic        wr_div;
  logic        wr_tima;
  logic        wr_tma;
  logic        wr_tac;
  logic [15:0] sys_cnt_next;
  logic [2:0]  tac_next;
  logic [7:0]  tma_next;
  logic        tick_in;
  logic        fall;
  logic        edge_next;

  function automatic logic tick_of(input logic [2:0] t, input logic [15:0] c);
    logic b;
    case (t[1:0])
      2'b00:   b = c[9];
      2'b01:   b = c[3];
      2'b10:   b = c[5];
      default: b = c[7];
    endcase
    return t[2] & b;
  endfunction

  assign mem_hit = mem_enable & (mem_addr[15:2] == BASE_ADDR[15:2]);
  assign wr_en   = mem_hit & mem_write & (t_cycle == 2'd3);
  assign wr_div  = wr_en & (mem_addr[1:0] == 2'd0);
  assign wr_tima = wr_en & (mem_addr[1:0] == 2'd1);
  assign wr_tma  = wr_en & (mem_addr[1:0] == 2'd2);
  assign wr_tac  = wr_en & (mem_addr[1:0] == 2'd3);

  always_comb begin
    mem_rdata = 8'hFF;
    if (mem_hit) begin
      case (mem_addr[1:0])
        2'd0:    mem_rdata = sys_cnt[15:8];
        2'd1:    mem_rdata = tima;
        2'd2:    mem_rdata = tma;
        default: mem_rdata = {5'b11111, tac};
      endcase
    end
  end

  assign sys_cnt_next = wr_div ? 16'd0 : sys_cnt + 16'd1;
  assign tac_next     = wr_tac ? mem_wdata[2:0] : tac;
  assign tma_next     = wr_tma ? mem_wdata : tma;
  assign tick_in      = tick_of(tac, sys_cnt);
  assign fall         = edge_prev & ~tick_in;

`ifdef TIMER_DIV_GLITCH_EN
  assign edge_next = tick_in;
`else
  // Seed the detector with the post-write tick so register writes never look like a falling edge.
  assign edge_next = (wr_div | wr_tac) ? tick_of(tac_next, sys_cnt_next) : tick_in;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sys_cnt   <= 16'd0;
      tima      <= 8'd0;
      tma       <= 8'd0;
      tac       <= 3'd0;
      state     <= IDLE;
      k         <= 2'd0;
      edge_prev <= 1'b0;
      irq_timer <= 1'b0;
    end else begin
      sys_cnt   <= sys_cnt_next;
      tac       <= tac_next;
      tma       <= tma_next;
      edge_prev <= edge_next;
      irq_timer <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_tima) begin
            tima <= mem_wdata;
          end else if (fall) begin
            tima <= tima + 8'd1;
            if (tima == 8'hFF) begin
              state <= PENDING;
              k     <= 2'd0;
            end
          end
        end
        PENDING: begin
          k <= k + 2'd1;
          if (wr_tima) begin
            tima  <= mem_wdata;
            state <= IDLE;
          end else if (k == 2'd3) begin
            tima      <= tma_next;
            irq_timer <= 1'b1;
            state     <= RELOAD;
          end else if (fall) begin
            tima <= tima + 8'd1;
          end
        end
        RELOAD: begin
          k <= k + 2'd1;
          // TIMA writes are dropped here; a TMA write lands in TIMA as well.
          if (wr_tma) begin
            tima <= mem_wdata;
          end else if (fall) begin
            tima <= tima + 8'd1;
          end
          if (k == 2'd3) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_timer_regs.sv
// tb_timer_regs: table-driven decode/reset checks plus hand sequences for TIMA overflow, reload window and DIV writes.
module tb_timer_regs;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  t_cycle;
  logic [15:0] mem_addr;
  logic        mem_enable;
  logic        mem_write;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_hit;
  logic        irq_timer;

  always #5 clk = ~clk;

  timer_regs #(.BASE_ADDR(16'hFF04)) dut (
    .clk(clk), .reset_n(reset_n), .t_cycle(t_cycle), .mem_addr(mem_addr),
    .mem_enable(mem_enable), .mem_write(mem_write), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_hit(mem_hit), .irq_timer(irq_timer)
  );

  typedef struct {
    string      name;
    logic [7:0] exp;
  } sb_t;

  typedef struct {
    logic        en;
    logic [15:0] addr;
    logic [7:0]  rdata;
    logic        hit;
    string       name;
  } vec_t;

  sb_t         sb_q[$];
  vec_t        vecs[8];
  int          tests = 0;
  int          fails = 0;
  int          irq_cnt = 0;
  logic [15:0] s;  // bench's own count of clk edges since the last DIV clear / reset release

  always @(negedge clk) if (irq_timer === 1'b1) irq_cnt++;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %02h expected %02h", name, act, exp);
    end else begin
      $display("[TB] ok   %s: %02h", name, act);
    end
  endtask

  task automatic step();
    @(negedge clk);
    s = s + 16'd1;
  endtask

  task automatic goto(input logic [15:0] target);
    for (int i = 0; i < 70000 && s != target; i++) step();
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d, input logic [1:0] tc);
    mem_enable = 1'b1; mem_write = 1'b1; mem_addr = a; mem_wdata = d; t_cycle = tc;
    @(negedge clk);
    mem_enable = 1'b0; mem_write = 1'b0; mem_addr = 16'h0000; t_cycle = 2'd0;
    if (a == 16'hFF04 && tc == 2'd3) s = 16'd0;
    else s = s + 16'd1;
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] exp, input string name);
    sb_t e;
    mem_enable = 1'b1; mem_write = 1'b0; mem_addr = a;
    e.name = name; e.exp = exp;
    sb_q.push_back(e);
    #1;
    e = sb_q.pop_front();
    check(e.name, mem_rdata, e.exp);
    mem_enable = 1'b0;
  endtask

  // Leaves TAC=05, TMA=80, TIMA=FE with s=1 and the edge detector low.
  task automatic setup_fe();
    wr(16'hFF07, 8'h00, 2'd3);
    wr(16'hFF06, 8'h80, 2'd3);
    wr(16'hFF05, 8'hFE, 2'd3);
    wr(16'hFF04, 8'h00, 2'd3);
    wr(16'hFF07, 8'h05, 2'd3);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int   base;
    sb_t  e;
    vecs[0] = '{1'b1, 16'hFF04, 8'h00, 1'b1, "rst_div"};
    vecs[1] = '{1'b1, 16'hFF05, 8'h00, 1'b1, "rst_tima"};
    vecs[2] = '{1'b1, 16'hFF06, 8'h00, 1'b1, "rst_tma"};
    vecs[3] = '{1'b1, 16'hFF07, 8'hF8, 1'b1, "rst_tac"};
    vecs[4] = '{1'b1, 16'hFF03, 8'hFF, 1'b0, "dec_ff03"};
    vecs[5] = '{1'b1, 16'hFF08, 8'hFF, 1'b0, "dec_ff08"};
    vecs[6] = '{1'b1, 16'h7F05, 8'hFF, 1'b0, "dec_7f05"};
    vecs[7] = '{1'b0, 16'hFF05, 8'hFF, 1'b0, "dec_noen"};

    reset_n = 1'b0; t_cycle = 2'd0; mem_addr = 16'h0000; mem_enable = 1'b0;
    mem_write = 1'b0; mem_wdata = 8'h00; s = 16'd0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1; s = 16'd0;
    goto(16'd300);
    rd(16'hFF04, 8'h01, "div_running");
    wr(16'hFF06, 8'h12, 2'd3);
    wr(16'hFF07, 8'h07, 2'd3);

    // Reset mid-count, clock keeps running while the table is applied.
    reset_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      mem_enable = vecs[i].en; mem_write = 1'b0; mem_addr = vecs[i].addr;
      e.name = vecs[i].name; e.exp = vecs[i].rdata;
      sb_q.push_back(e);
      #1;
      e = sb_q.pop_front();
      check(e.name, mem_rdata, e.exp);
      check({e.name, "_hit"}, {7'd0, mem_hit}, {7'd0, vecs[i].hit});
      mem_enable = 1'b0;
    end
    check("rst_irq", {7'd0, irq_timer}, 8'h00);
    @(negedge clk);
    reset_n = 1'b1; s = 16'd0;

    // Out-of-range and wrong-phase writes must not change anything.
    wr(16'hFF03, 8'h07, 2'd3);
    wr(16'hFF08, 8'h00, 2'd3);
    wr(16'h7F05, 8'h55, 2'd3);
    wr(16'hFF06, 8'h99, 2'd1);
    rd(16'hFF07, 8'hF8, "dec_wr_tac");
    rd(16'hFF05, 8'h00, "dec_wr_tima");
    rd(16'hFF06, 8'h00, "phase_wr_tma");
    goto(16'd255);
    rd(16'hFF04, 8'h00, "div_255");
    goto(16'd256);
    rd(16'hFF04, 8'h01, "div_256");

    // Free-running overflow and reload.
    setup_fe();
    goto(16'h10); rd(16'hFF05, 8'hFE, "run_fe");
    goto(16'h11); rd(16'hFF05, 8'hFF, "run_ff");
    goto(16'h20); rd(16'hFF05, 8'hFF, "run_ff_hold");
    goto(16'h21); rd(16'hFF05, 8'h00, "run_pend0");
    goto(16'h24); rd(16'hFF05, 8'h00, "run_pend3");
    check("run_irq_pre", {7'd0, irq_timer}, 8'h00);
    base = irq_cnt;
    goto(16'h25); rd(16'hFF05, 8'h80, "run_reload");
    check("run_irq", {7'd0, irq_timer}, 8'h01);
    goto(16'h26); check("run_irq_post", {7'd0, irq_timer}, 8'h00);
    goto(16'h30); rd(16'hFF05, 8'h80, "run_80_hold");
    goto(16'h31); rd(16'hFF05, 8'h81, "run_81");
    check("run_irq_cnt", 8'(irq_cnt - base), 8'h01);

    // TIMA write during PENDING cancels the reload.
    setup_fe();
    goto(16'h21); rd(16'hFF05, 8'h00, "cancel_pend");
    goto(16'h22); base = irq_cnt;
    wr(16'hFF05, 8'h42, 2'd3);
    rd(16'hFF05, 8'h42, "cancel_wr");
    goto(16'h2A); rd(16'hFF05, 8'h42, "cancel_noreload");
    check("cancel_irq_cnt", 8'(irq_cnt - base), 8'h00);
    goto(16'h31); rd(16'hFF05, 8'h43, "cancel_next");

    // Writes inside the RELOAD window.
    setup_fe();
    goto(16'h24); base = irq_cnt;
    goto(16'h25); rd(16'hFF05, 8'h80, "rl_start");
    wr(16'hFF05, 8'h11, 2'd3);
    rd(16'hFF05, 8'h80, "rl_tima_ignored");
    wr(16'hFF06, 8'h33, 2'd3);
    rd(16'hFF05, 8'h33, "rl_tma_to_tima");
    rd(16'hFF06, 8'h33, "rl_tma");
    goto(16'h31); rd(16'hFF05, 8'h34, "rl_next");
    check("rl_irq_cnt", 8'(irq_cnt - base), 8'h01);

    // TIMA write coinciding with a tick, then with an overflow.
    setup_fe();
    goto(16'h10); wr(16'hFF05, 8'h50, 2'd3);
    rd(16'hFF05, 8'h50, "wr_beats_tick");
    setup_fe();
    goto(16'h20); base = irq_cnt;
    wr(16'hFF05, 8'h60, 2'd3);
    rd(16'hFF05, 8'h60, "wr_beats_ovf");
    goto(16'h29); rd(16'hFF05, 8'h60, "wr_beats_ovf_hold");
    check("wr_ovf_irq_cnt", 8'(irq_cnt - base), 8'h00);
    goto(16'h31); rd(16'hFF05, 8'h61, "wr_ovf_next");

    // Reset while PENDING aborts without an interrupt.
    setup_fe();
    goto(16'h22); base = irq_cnt;
    reset_n = 1'b0;
    rd(16'hFF05, 8'h00, "rstp_tima");
    check("rstp_irq", {7'd0, irq_timer}, 8'h00);
    repeat (3) @(negedge clk);
    reset_n = 1'b1; s = 16'd0;
    goto(16'd10);
    rd(16'hFF05, 8'h00, "rstp_tima_after");
    rd(16'hFF06, 8'h00, "rstp_tma_after");
    check("rstp_irq_cnt", 8'(irq_cnt - base), 8'h00);

    // DIV write while the selected bit is high.
    setup_fe();
    goto(16'h08); wr(16'hFF04, 8'hA5, 2'd3);
    rd(16'hFF04, 8'h00, "divwr_div");
    step(); step();
`ifdef TIMER_DIV_GLITCH_EN
    rd(16'hFF05, 8'hFF, "divwr_tima");
`else
    rd(16'hFF05, 8'hFE, "divwr_tima");
`endif
    // TAC write that drops the tick from 1 to 0.
    goto(16'h08); wr(16'hFF07, 8'h04, 2'd3);
    step();
`ifdef TIMER_DIV_GLITCH_EN
    rd(16'hFF05, 8'h00, "tacwr_tima");
`else
    rd(16'hFF05, 8'hFE, "tacwr_tima");
`endif
    wr(16'hFF07, 8'h1E, 2'd3);
    rd(16'hFF07, 8'hFE, "tac_upper");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
